// File: rtl/double_pulse_monitor.sv
// Receive-side checker for a double-pulse gate waveform.
// Measures first high, gap and second high widths in clk cycles, checks each
// against an expected window, and reports a pass flag plus fault bits per shot.
module double_pulse_monitor #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned H1_EXP  = 4000,
  parameter int unsigned L1_EXP  = 800,
  parameter int unsigned H2_EXP  = 1200,
  parameter int unsigned TOL     = 8,
  parameter int unsigned TIMEOUT = 400000,
  parameter int unsigned QUIET   = 40000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate_in,
  input  logic             arm,
  output logic [CNT_W-1:0] meas_h1,
  output logic [CNT_W-1:0] meas_l1,
  output logic [CNT_W-1:0] meas_h2,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] H1_LO   = CNT_W'(H1_EXP - TOL);
  localparam logic [CNT_W-1:0] H1_HI   = CNT_W'(H1_EXP + TOL);
  localparam logic [CNT_W-1:0] L1_LO   = CNT_W'(L1_EXP - TOL);
  localparam logic [CNT_W-1:0] L1_HI   = CNT_W'(L1_EXP + TOL);
  localparam logic [CNT_W-1:0] H2_LO   = CNT_W'(H2_EXP - TOL);
  localparam logic [CNT_W-1:0] H2_HI   = CNT_W'(H2_EXP + TOL);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] QT_LIM  = CNT_W'(QUIET);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    H1   = 3'd1,
    L1   = 3'd2,
    H2   = 3'd3,
    TAIL = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, d;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] meas_h1_nxt, meas_l1_nxt, meas_h2_nxt;
  // measured-in-this-shot flags: {h2, l1, h1}
  logic [2:0]       mflag, mflag_nxt;
  logic             acc_extra, acc_extra_nxt;
  logic             acc_to, acc_to_nxt;
  logic             finish_c;
  logic             bad_h1, bad_l1, bad_h2;
  logic [4:0]       err_c;

  // Two-flop synchronizer plus delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= gate_in;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign rise    = s2 & ~d;
  assign fall    = ~s2 & d;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, counter and measurement capture
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    meas_h1_nxt   = meas_h1;
    meas_l1_nxt   = meas_l1;
    meas_h2_nxt   = meas_h2;
    mflag_nxt     = mflag;
    acc_extra_nxt = acc_extra;
    acc_to_nxt    = acc_to;
    finish_c      = 1'b0;
    case (state)
      IDLE: begin
        if (rise && arm) begin
          state_nxt     = H1;
          cnt_nxt       = CNT_ONE;
          mflag_nxt     = 3'b000;
          acc_extra_nxt = 1'b0;
          acc_to_nxt    = 1'b0;
        end
      end
      H1: begin
        if (fall) begin
          meas_h1_nxt  = cnt;
          mflag_nxt[0] = 1'b1;
          cnt_nxt      = CNT_ONE;
          state_nxt    = L1;
        end else if (cnt >= TO_LIM) begin
          acc_to_nxt = 1'b1;
          finish_c   = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      L1: begin
        if (rise) begin
          meas_l1_nxt  = cnt;
          mflag_nxt[1] = 1'b1;
          cnt_nxt      = CNT_ONE;
          state_nxt    = H2;
        end else if (cnt >= TO_LIM) begin
          acc_to_nxt = 1'b1;
          finish_c   = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      H2: begin
        if (fall) begin
          meas_h2_nxt  = cnt;
          mflag_nxt[2] = 1'b1;
          cnt_nxt      = CNT_ONE;
          state_nxt    = TAIL;
        end else if (cnt >= TO_LIM) begin
          acc_to_nxt = 1'b1;
          finish_c   = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      TAIL: begin
        if (rise) begin
          acc_extra_nxt = 1'b1;
          finish_c      = 1'b1;
          state_nxt     = IDLE;
        end else if (cnt >= QT_LIM) begin
          finish_c  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window checks only for phases measured in the current shot
  assign bad_h1 = mflag_nxt[0] && ((meas_h1_nxt < H1_LO) || (meas_h1_nxt > H1_HI));
  assign bad_l1 = mflag_nxt[1] && ((meas_l1_nxt < L1_LO) || (meas_l1_nxt > L1_HI));
  assign bad_h2 = mflag_nxt[2] && ((meas_h2_nxt < H2_LO) || (meas_h2_nxt > H2_HI));
  assign err_c  = {acc_extra_nxt, acc_to_nxt, bad_h2, bad_l1, bad_h1};

  // Datapath and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      meas_h1   <= '0;
      meas_l1   <= '0;
      meas_h2   <= '0;
      mflag     <= 3'b000;
      acc_extra <= 1'b0;
      acc_to    <= 1'b0;
      err       <= 5'b00000;
      pass      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      meas_h1   <= meas_h1_nxt;
      meas_l1   <= meas_l1_nxt;
      meas_h2   <= meas_h2_nxt;
      mflag     <= mflag_nxt;
      acc_extra <= acc_extra_nxt;
      acc_to    <= acc_to_nxt;
      done      <= finish_c;
      busy      <= (state_nxt != IDLE);
      if (finish_c) begin
        err  <= err_c;
        pass <= (err_c == 5'b00000);
      end
    end
  end

endmodule

// File: tb/tb_double_pulse_monitor.sv
// Directed bench for double_pulse_monitor with scaled-down windows.
module tb_double_pulse_monitor;

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned H1_EXP  = 40;
  localparam int unsigned L1_EXP  = 20;
  localparam int unsigned H2_EXP  = 30;
  localparam int unsigned TOL     = 4;
  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned QUIET   = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             gate_in;
  logic             arm;
  logic [CNT_W-1:0] meas_h1, meas_l1, meas_h2;
  logic             done, pass, busy;
  logic [4:0]       err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int k;
  int d0, b0;

  double_pulse_monitor #(
    .CNT_W(CNT_W), .H1_EXP(H1_EXP), .L1_EXP(L1_EXP), .H2_EXP(H2_EXP),
    .TOL(TOL), .TIMEOUT(TIMEOUT), .QUIET(QUIET)
  ) dut (
    .clk(clk), .rst(rst), .gate_in(gate_in), .arm(arm),
    .meas_h1(meas_h1), .meas_l1(meas_l1), .meas_h2(meas_h2),
    .done(done), .pass(pass), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count done pulses and busy cycles
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold gate at v for n clock edges; returns at posedge+2
  task automatic gate_hold(input logic v, input int n);
    gate_in = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic burst(input int h1, input int l1, input int h2);
    gate_hold(1'b1, h1);
    gate_hold(1'b0, l1);
    gate_hold(1'b1, h2);
    gate_in = 1'b0;
  endtask

  // Count edges until done is seen; an expired bound is a failed check
  task automatic wait_done(output int kk, input int limit);
    kk = 0;
    while (done !== 1'b1 && kk < limit) begin
      @(posedge clk);
      #1;
      kk++;
    end
    checks++;
    assert (kk < limit) else begin
      errors++;
      $error("FAIL done_timeout observed %0d expected <%0d", kk, limit);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; gate_in = 1'b0; arm = 1'b0;
    #1;
    chk("rst_meas_h1", 32'(meas_h1), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    gate_hold(1'b0, 5);

    // Nominal shot
    arm = 1'b1; d0 = done_cnt;
    burst(40, 20, 30);
    wait_done(k, QUIET + 20);
    chk("nom_latency", 32'(k), QUIET + 3);
    chk("nom_h1", 32'(meas_h1), 40);
    chk("nom_l1", 32'(meas_l1), 20);
    chk("nom_h2", 32'(meas_h2), 30);
    chk("nom_err", 32'(err), 0);
    chk("nom_pass", 32'(pass), 1);
    chk("nom_busy", 32'(busy), 0);
    gate_hold(1'b0, 10);
    chk("nom_single_done", 32'(done_cnt - d0), 1);

    // Upper window edge on H1
    burst(44, 20, 30);
    wait_done(k, QUIET + 20);
    chk("h1_44_h1", 32'(meas_h1), 44);
    chk("h1_44_pass", 32'(pass), 1);
    chk("h1_44_err", 32'(err), 0);
    gate_hold(1'b0, 10);
    burst(45, 20, 30);
    wait_done(k, QUIET + 20);
    chk("h1_45_err", 32'(err), 5'b00001);
    chk("h1_45_pass", 32'(pass), 0);
    gate_hold(1'b0, 10);

    // Lower window edge on H2
    burst(40, 20, 25);
    wait_done(k, QUIET + 20);
    chk("h2_25_err", 32'(err), 5'b00100);
    gate_hold(1'b0, 10);

    // In-window off-nominal shot, leaves distinctive L1/H2 values
    burst(40, 23, 33);
    wait_done(k, QUIET + 20);
    chk("off_err", 32'(err), 0);
    chk("off_pass", 32'(pass), 1);
    gate_hold(1'b0, 10);

    // Timeout in L1 after a single pulse
    gate_hold(1'b1, 42);
    gate_in = 1'b0;
    wait_done(k, TIMEOUT + 20);
    chk("to_latency", 32'(k), TIMEOUT + 3);
    chk("to_err", 32'(err), 5'b01000);
    chk("to_pass", 32'(pass), 0);
    chk("to_h1", 32'(meas_h1), 42);
    chk("to_l1_kept", 32'(meas_l1), 23);
    chk("to_h2_kept", 32'(meas_h2), 33);
    gate_hold(1'b0, 10);

    // Extra pulse in the quiet window
    d0 = done_cnt;
    burst(40, 20, 30);
    gate_hold(1'b0, 10);
    gate_in = 1'b1;
    wait_done(k, 20);
    chk("xp_latency", 32'(k), 3);
    chk("xp_err", 32'(err), 5'b10000);
    chk("xp_pass", 32'(pass), 0);
    chk("xp_h2", 32'(meas_h2), 30);
    gate_hold(1'b1, 50);
    gate_hold(1'b0, QUIET + 20);
    chk("xp_single_done", 32'(done_cnt - d0), 1);

    // Disarmed burst is ignored
    arm = 1'b0; d0 = done_cnt; b0 = busy_cyc;
    burst(40, 20, 30);
    gate_hold(1'b0, QUIET + 20);
    chk("noarm_done", 32'(done_cnt - d0), 0);
    chk("noarm_busy", 32'(busy_cyc - b0), 0);

    // Arm dropped mid-H2 does not abort
    arm = 1'b1;
    gate_hold(1'b1, 40);
    gate_hold(1'b0, 20);
    gate_hold(1'b1, 10);
    arm = 1'b0;
    gate_hold(1'b1, 20);
    gate_in = 1'b0;
    wait_done(k, QUIET + 20);
    chk("armdrop_pass", 32'(pass), 1);
    chk("armdrop_h2", 32'(meas_h2), 30);
    gate_hold(1'b0, 10);

    // Reset in L1 aborts the shot
    arm = 1'b1; d0 = done_cnt;
    gate_hold(1'b1, 40);
    gate_hold(1'b0, 5);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_h1", 32'(meas_h1), 0);
    chk("rstmid_l1", 32'(meas_l1), 0);
    chk("rstmid_h2", 32'(meas_h2), 0);
    chk("rstmid_err", 32'(err), 0);
    chk("rstmid_pass", 32'(pass), 0);
    chk("rstmid_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    gate_hold(1'b0, QUIET + 20);
    chk("rstmid_no_done", 32'(done_cnt - d0), 0);
    burst(40, 20, 30);
    wait_done(k, QUIET + 20);
    chk("post_h1", 32'(meas_h1), 40);
    chk("post_l1", 32'(meas_l1), 20);
    chk("post_h2", 32'(meas_h2), 30);
    chk("post_pass", 32'(pass), 1);
    gate_hold(1'b0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/double_pulse_monitor.md
# double_pulse_monitor

Receive-side checker for the double-pulse gate drive: samples the gate line (K1 feedback from the board), measures first-pulse high time, inter-pulse low time and second-pulse high time in clk cycles, and compares each against an expected window. Sits beside the double-pulse generator on the test PCB. It reports measured widths, a pass flag and per-fault error bits once per test shot, so bench firmware or LEDs can confirm the waveform actually reached the pin.

## Interface
- CNT_W, 24: width of all counters and measurement outputs.
- H1_EXP, 4000: expected first high width, cycles (100 us at 40 MHz).
- L1_EXP, 800: expected gap width, cycles.
- H2_EXP, 1200: expected second high width, cycles.
- TOL, 8: allowed ± deviation, cycles; each *_EXP must be ≥ TOL.
- TIMEOUT, 400000: maximum cycles any single phase may last.
- QUIET, 40000: post-pulse window in which the gate must stay low.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- gate_in  in  1  gate line under test, asynchronous to clk.
- arm  in  1  level; a measurement starts only from IDLE while arm=1.
- meas_h1  out  CNT_W  last measured first high width.
- meas_l1  out  CNT_W  last measured gap width.
- meas_h2  out  CNT_W  last measured second high width.
- done  out  1  one-cycle pulse when a shot's result is final.
- pass  out  1  1 when the last completed shot had err=0.
- err  out  5  {extra_pulse, timeout, h2_bad, l1_bad, h1_bad}, held.
- busy  out  1  1 in any state except IDLE.

## Operation
- gate_in passes a 2-flop synchronizer (reset 0) then a delay flop; rise = s2 & ~d, fall = ~s2 & d.
- States: IDLE, H1, L1, H2, TAIL.
- IDLE: on rise with arm=1 -> H1, cnt<=1, clear err accumulator.
- H1: fall -> meas_h1<=cnt, cnt<=1, -> L1; otherwise cnt+1.
- L1: rise -> meas_l1<=cnt, cnt<=1, -> H2; otherwise cnt+1.
- H2: fall -> meas_h2<=cnt, cnt<=1, -> TAIL; otherwise cnt+1.
- TAIL: rise -> set extra_pulse, finish; cnt reaching QUIET -> finish; otherwise cnt+1.
- Measured width of an N-cycle synchronized pulse is exactly N (synchronizer delay cancels).
- Timeout: in H1/L1/H2, cnt reaching TIMEOUT sets timeout and finishes; unmeasured meas_* keep their previous values.
- Finish: window flags computed as meas < EXP−TOL or meas > EXP+TOL (unsigned, CNT_W wide); err, pass registered; done=1 for one cycle; -> IDLE.
- h*_bad/l1_bad are set only for phases actually measured in this shot.
- cnt saturates at all-ones; never wraps.
- arm is ignored outside IDLE; dropping arm mid-shot does not abort.
- After extra_pulse finish, the rest of that pulse is ignored; next rise with arm=1 starts a new shot.

## Timing
- Reset (async assert, sync release): state IDLE, cnt 0, sync flops 0, meas_* 0, err 0, pass 0, done 0, busy 0.
- gate_in edge to internal rise/fall detect: 2–3 clk cycles.
- busy rises the cycle after the arming rise detect.
- done asserts the cycle after the finishing event (QUIET expiry, TAIL rise, or timeout); meas_*, err, pass valid in the same cycle as done and held until the next done.
- Rise in IDLE with arm=1 coincident with reset release: ignored (reset wins).
- Reset mid-shot aborts immediately, no done.

## Test plan
- Nominal: arm=1, gate 4000 high / 800 low / 1200 high, then low -> meas 4000/800/1200, err=0, pass=1, single done QUIET+~3 cycles after second fall.
- Window edges: H1=4008 and H1=4009 (L1, H2 nominal) -> first pass=1, second err=00001, pass=0.
- Timeout: single 4000-cycle pulse, gate stays low -> done with err=01000, meas_h1=4000, meas_l1/meas_h2 unchanged from the previous shot.
- Extra pulse: nominal pair then third pulse 100 cycles after second fall -> err=10000, pass=0, done ~3 cycles after third rise; no second done.
- Arm gating: arm=0 during full nominal burst -> busy=0, no done; arm dropped mid-H2 -> shot completes with pass=1.
- Reset mid-L1 -> all outputs 0, busy=0, no done; next nominal burst measures correctly.
